// File: rtl/ysyx_22041071_opread_if.sv
// Operand-read stage bundle: decoded-instruction input, forwarding sources,
// EX-facing pipeline register, debug port and stall counter.
interface ysyx_22041071_opread_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned AW    = 5,
    parameter int unsigned CTRLW = 16,
    parameter int unsigned CNTW  = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [AW-1:0]    in_rs1;
    logic [AW-1:0]    in_rs2;
    logic             in_rs1_used;
    logic             in_rs2_used;
    logic [XLEN-1:0]  in_imm;
    logic [1:0]       in_src1_sel;
    logic [1:0]       in_src2_sel;
    logic [AW-1:0]    in_rd;
    logic             in_rd_wen;
    logic             in_is_load;
    logic [CTRLW-1:0] in_ctrl;

    logic             ex_wen;
    logic             ex_is_load;
    logic [AW-1:0]    ex_rd;
    logic [XLEN-1:0]  ex_data;
    logic             mem_wen;
    logic [AW-1:0]    mem_rd;
    logic [XLEN-1:0]  mem_data;
    logic             wb_wen;
    logic [AW-1:0]    wb_rd;
    logic [XLEN-1:0]  wb_data;

    logic             flush;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_src_a;
    logic [XLEN-1:0]  out_src_b;
    logic [XLEN-1:0]  out_rs2_data;
    logic [AW-1:0]    out_rd;
    logic             out_rd_wen;
    logic             out_is_load;
    logic [CTRLW-1:0] out_ctrl;

    logic [AW-1:0]    dbg_addr;
    logic [XLEN-1:0]  dbg_data;
    logic [CNTW-1:0]  stall_cnt;

    modport master (
        output in_valid, in_pc, in_rs1, in_rs2, in_rs1_used, in_rs2_used, in_imm,
               in_src1_sel, in_src2_sel, in_rd, in_rd_wen, in_is_load, in_ctrl,
               ex_wen, ex_is_load, ex_rd, ex_data, mem_wen, mem_rd, mem_data,
               wb_wen, wb_rd, wb_data, flush, out_ready, dbg_addr,
        input  in_ready, out_valid, out_pc, out_src_a, out_src_b, out_rs2_data,
               out_rd, out_rd_wen, out_is_load, out_ctrl, dbg_data, stall_cnt
    );

    modport slave (
        input  in_valid, in_pc, in_rs1, in_rs2, in_rs1_used, in_rs2_used, in_imm,
               in_src1_sel, in_src2_sel, in_rd, in_rd_wen, in_is_load, in_ctrl,
               ex_wen, ex_is_load, ex_rd, ex_data, mem_wen, mem_rd, mem_data,
               wb_wen, wb_rd, wb_data, flush, out_ready, dbg_addr,
        output in_ready, out_valid, out_pc, out_src_a, out_src_b, out_rs2_data,
               out_rd, out_rd_wen, out_is_load, out_ctrl, dbg_data, stall_cnt
    );
endinterface

// File: rtl/ysyx_22041071_opread.sv
// Operand-read stage: register file, EX/MEM/WB forwarding, load-use bubble
// insertion and a valid/ready pipeline register toward EX.
module ysyx_22041071_opread #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREG  = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned CTRLW = 16,
    parameter int unsigned CNTW  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    ysyx_22041071_opread_if.slave  bus
);

    logic [XLEN-1:0] rf_q [NREG];

    logic             valid_q, valid_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  src_a_q, src_a_d;
    logic [XLEN-1:0]  src_b_q, src_b_d;
    logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic             rd_wen_q, rd_wen_d;
    logic             is_load_q, is_load_d;
    logic [CTRLW-1:0] ctrl_q, ctrl_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic            hazard, adv, accept, in_ready;
    logic [XLEN-1:0] rs1_val, rs2_val;

    // Load results are not available in EX yet, so an EX load never forwards.
    function automatic logic [XLEN-1:0] resolve(
        input logic [AW-1:0]   rs,
        input logic [XLEN-1:0] rf_val,
        input logic            ex_fwd,
        input logic [AW-1:0]   ex_rd,
        input logic [XLEN-1:0] ex_data,
        input logic            mem_wen,
        input logic [AW-1:0]   mem_rd,
        input logic [XLEN-1:0] mem_data,
        input logic            wb_wen,
        input logic [AW-1:0]   wb_rd,
        input logic [XLEN-1:0] wb_data
    );
        if (rs == '0)                        return '0;
        else if (ex_fwd && ex_rd == rs)      return ex_data;
        else if (mem_wen && mem_rd == rs)    return mem_data;
        else if (wb_wen && wb_rd == rs)      return wb_data;
        else                                 return rf_val;
    endfunction

    always_comb begin
        rs1_val = resolve(bus.in_rs1, rf_q[bus.in_rs1], bus.ex_wen && !bus.ex_is_load,
                          bus.ex_rd, bus.ex_data, bus.mem_wen, bus.mem_rd, bus.mem_data,
                          bus.wb_wen, bus.wb_rd, bus.wb_data);
        rs2_val = resolve(bus.in_rs2, rf_q[bus.in_rs2], bus.ex_wen && !bus.ex_is_load,
                          bus.ex_rd, bus.ex_data, bus.mem_wen, bus.mem_rd, bus.mem_data,
                          bus.wb_wen, bus.wb_rd, bus.wb_data);
    end

    always_comb begin
        hazard = bus.in_valid && bus.ex_wen && bus.ex_is_load && (bus.ex_rd != '0) &&
                 ((bus.in_rs1_used && bus.in_rs1 == bus.ex_rd) ||
                  (bus.in_rs2_used && bus.in_rs2 == bus.ex_rd));
        adv      = !valid_q || bus.out_ready;
        in_ready = adv && !hazard && !bus.flush;
        accept   = bus.in_valid && in_ready;
    end

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        src_a_d    = src_a_q;
        src_b_d    = src_b_q;
        rs2_data_d = rs2_data_q;
        rd_d       = rd_q;
        rd_wen_d   = rd_wen_q;
        is_load_d  = is_load_q;
        ctrl_d     = ctrl_q;
        cnt_d      = cnt_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (adv) begin
            valid_d = accept;
            if (hazard && cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (accept) begin
                pc_d       = bus.in_pc;
                rs2_data_d = rs2_val;
                rd_d       = bus.in_rd;
                rd_wen_d   = bus.in_rd_wen && (bus.in_rd != '0);
                is_load_d  = bus.in_is_load;
                ctrl_d     = bus.in_ctrl;
                unique case (bus.in_src1_sel)
                    2'd0:    src_a_d = rs1_val;
                    2'd2:    src_a_d = bus.in_pc;
                    default: src_a_d = '0;
                endcase
                unique case (bus.in_src2_sel)
                    2'd0:    src_b_d = rs2_val;
                    2'd1:    src_b_d = bus.in_imm;
                    2'd2:    src_b_d = XLEN'(4);
                    default: src_b_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
        end else if (bus.wb_wen && bus.wb_rd != '0) begin
            rf_q[bus.wb_rd] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            src_a_q    <= '0;
            src_b_q    <= '0;
            rs2_data_q <= '0;
            rd_q       <= '0;
            rd_wen_q   <= 1'b0;
            is_load_q  <= 1'b0;
            ctrl_q     <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            src_a_q    <= src_a_d;
            src_b_q    <= src_b_d;
            rs2_data_q <= rs2_data_d;
            rd_q       <= rd_d;
            rd_wen_q   <= rd_wen_d;
            is_load_q  <= is_load_d;
            ctrl_q     <= ctrl_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = valid_q;
    assign bus.out_pc       = pc_q;
    assign bus.out_src_a    = src_a_q;
    assign bus.out_src_b    = src_b_q;
    assign bus.out_rs2_data = rs2_data_q;
    assign bus.out_rd       = rd_q;
    assign bus.out_rd_wen   = rd_wen_q;
    assign bus.out_is_load  = is_load_q;
    assign bus.out_ctrl     = ctrl_q;
    assign bus.dbg_data     = (bus.dbg_addr == '0) ? '0 : rf_q[bus.dbg_addr];
    assign bus.stall_cnt    = cnt_q;

endmodule

// File: tb/tb_ysyx_22041071_opread.sv
// Directed bench for the operand-read stage: forwarding priority, load-use
// bubble, backpressure, flush, x0 handling and asynchronous reset.
module tb_ysyx_22041071_opread;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    ysyx_22041071_opread_if #(.XLEN(64), .AW(5), .CTRLW(16), .CNTW(32)) bus ();

    ysyx_22041071_opread #(
        .XLEN(64), .NREG(32), .AW(5), .CTRLW(16), .CNTW(32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.in_valid = 0; bus.in_pc = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
        bus.in_rs1_used = 0; bus.in_rs2_used = 0; bus.in_imm = '0;
        bus.in_src1_sel = '0; bus.in_src2_sel = '0; bus.in_rd = '0; bus.in_rd_wen = 0;
        bus.in_is_load = 0; bus.in_ctrl = '0;
        bus.ex_wen = 0; bus.ex_is_load = 0; bus.ex_rd = '0; bus.ex_data = '0;
        bus.mem_wen = 0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.wb_wen = 0; bus.wb_rd = '0; bus.wb_data = '0;
        bus.flush = 0; bus.out_ready = 1; bus.dbg_addr = '0;

        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
        reset = 1'b1;

        // Fill r3 through WB, then try to write x0.
        bus.wb_wen = 1; bus.wb_rd = 5'd3; bus.wb_data = 64'h1234;
        tick();
        bus.wb_rd = 5'd0; bus.wb_data = 64'hFF;
        tick();
        bus.wb_wen = 0;
        bus.dbg_addr = 5'd3; #1;
        chk("dbg_r3", bus.dbg_data, 64'h1234);
        bus.dbg_addr = 5'd0; #1;
        chk("dbg_x0_after_write", bus.dbg_data, 64'd0);

        // Plain issue: rs1 from regfile, src_b = imm.
        bus.in_valid = 1; bus.in_pc = 64'h8000_0000; bus.in_rs1 = 5'd3; bus.in_rs1_used = 1;
        bus.in_src1_sel = 2'd0; bus.in_src2_sel = 2'd1; bus.in_imm = 64'h10;
        bus.in_rd = 5'd4; bus.in_rd_wen = 1; bus.in_ctrl = 16'hABCD; #1;
        chk("issue_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        chk("issue_valid", 64'(bus.out_valid), 64'd1);
        chk("issue_src_a", bus.out_src_a, 64'h1234);
        chk("issue_src_b", bus.out_src_b, 64'h10);
        chk("issue_pc", bus.out_pc, 64'h8000_0000);
        chk("issue_rd", 64'(bus.out_rd), 64'd4);
        chk("issue_rd_wen", 64'(bus.out_rd_wen), 64'd1);
        chk("issue_ctrl", 64'(bus.out_ctrl), 64'hABCD);

        // Forwarding priority EX > MEM > WB, src_b = constant 4.
        bus.ex_wen = 1; bus.ex_rd = 5'd5; bus.ex_data = 64'h11;
        bus.mem_wen = 1; bus.mem_rd = 5'd5; bus.mem_data = 64'h22;
        bus.wb_wen = 1; bus.wb_rd = 5'd5; bus.wb_data = 64'h33;
        bus.in_rs1 = 5'd5; bus.in_src2_sel = 2'd2;
        tick();
        chk("fwd_ex", bus.out_src_a, 64'h11);
        chk("src_b_const4", bus.out_src_b, 64'd4);
        bus.ex_wen = 0;
        tick();
        chk("fwd_mem", bus.out_src_a, 64'h22);
        bus.mem_wen = 0;
        tick();
        chk("fwd_wb", bus.out_src_a, 64'h33);
        bus.wb_wen = 0;

        // r5 now in regfile; src_a = PC, src_b = rs2 from regfile.
        bus.in_pc = 64'h100; bus.in_src1_sel = 2'd2; bus.in_rs2 = 5'd5; bus.in_rs2_used = 1;
        bus.in_src2_sel = 2'd0;
        tick();
        chk("src_a_pc", bus.out_src_a, 64'h100);
        chk("src_b_rf", bus.out_src_b, 64'h33);
        chk("rs2_data_rf", bus.out_rs2_data, 64'h33);

        // Load-use on rs2.
        bus.in_rs1 = 5'd0; bus.in_src1_sel = 2'd1; bus.in_rs2 = 5'd7; bus.in_src2_sel = 2'd3;
        bus.in_pc = 64'h104;
        bus.ex_wen = 1; bus.ex_is_load = 1; bus.ex_rd = 5'd7; bus.ex_data = 64'hDEAD; #1;
        chk("lu_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        chk("lu_bubble", 64'(bus.out_valid), 64'd0);
        chk("lu_stall_cnt", 64'(bus.stall_cnt), 64'd1);
        bus.ex_wen = 0; bus.ex_is_load = 0;
        bus.mem_wen = 1; bus.mem_rd = 5'd7; bus.mem_data = 64'hAB; #1;
        chk("lu_release_ready", 64'(bus.in_ready), 64'd1);
        tick();
        chk("lu_issue_valid", 64'(bus.out_valid), 64'd1);
        chk("lu_rs2_data", bus.out_rs2_data, 64'hAB);
        chk("lu_src_b_zero", bus.out_src_b, 64'd0);
        chk("lu_src_a_zero", bus.out_src_a, 64'd0);
        chk("lu_stall_cnt_hold", 64'(bus.stall_cnt), 64'd1);
        bus.mem_wen = 0;

        // Backpressure: outputs hold while a new instruction waits.
        bus.out_ready = 0;
        bus.in_pc = 64'h200; bus.in_rs1 = 5'd3; bus.in_src1_sel = 2'd0;
        bus.in_rs2 = 5'd0; bus.in_src2_sel = 2'd0; #1;
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_pc_hold", bus.out_pc, 64'h104);
            chk("bp_rs2_hold", bus.out_rs2_data, 64'hAB);
        end
        bus.out_ready = 1; #1;
        chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
        tick();
        chk("bp_next_pc", bus.out_pc, 64'h200);
        chk("bp_next_src_a", bus.out_src_a, 64'h1234);

        // Flush with a pending hazard: no stall counted.
        bus.flush = 1; bus.in_pc = 64'h300;
        bus.ex_wen = 1; bus.ex_is_load = 1; bus.ex_rd = 5'd3; #1;
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_stall_cnt", 64'(bus.stall_cnt), 64'd1);
        bus.flush = 0; bus.ex_wen = 0; bus.ex_is_load = 0;

        // x0: reads as zero even with forwarding sources aimed at it.
        bus.ex_wen = 1; bus.ex_rd = 5'd0; bus.ex_data = 64'h77;
        bus.wb_wen = 1; bus.wb_rd = 5'd0; bus.wb_data = 64'hFF;
        bus.in_rs1 = 5'd0; bus.in_src1_sel = 2'd0; bus.in_rd = 5'd0; bus.in_rd_wen = 1;
        tick();
        chk("x0_valid", 64'(bus.out_valid), 64'd1);
        chk("x0_src_a", bus.out_src_a, 64'd0);
        chk("x0_rd_wen", 64'(bus.out_rd_wen), 64'd0);
        bus.dbg_addr = 5'd0; #1;
        chk("x0_dbg", bus.dbg_data, 64'd0);
        bus.ex_wen = 0; bus.wb_wen = 0;

        // Reset mid-operation with a valid instruction in the output register.
        bus.in_rd = 5'd4; bus.in_rs1 = 5'd3;
        tick();
        chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        #2;
        reset = 1'b0; #1;
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("mid_rst_src_a", bus.out_src_a, 64'd0);
        for (int a = 0; a < 32; a++) begin
            bus.dbg_addr = 5'(a); #1;
            chk("mid_rst_rf", bus.dbg_data, 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
